// File: rtl/serial_prog_seq.sv
// Program sequencer: writable opcode store, program counter, bit-slot counter and run/stop control.
// Optional macro SERIAL_SEQ_LOOP_EN: the last-slot increment wraps to slot 0 instead of entering DONE.
module serial_prog_seq #(
  parameter int unsigned PROG_LEN = 8,
  parameter int unsigned PC_W     = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1,
  parameter int unsigned BIT_W    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pcincr,
  input  logic             i_prog_we,
  input  logic [PC_W-1:0]  i_prog_addr,
  input  logic [2:0]       i_prog_data,
  output logic [2:0]       o_instr,
  output logic [BIT_W-1:0] o_bit_count,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap,
  output logic             o_wr_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [BIT_W-1:0] bit_count_q, bit_count_d;
  logic             start_q;
  logic             wr_err_q, wr_err_d;
  logic [2:0]       store_q [PROG_LEN];
  logic [31:0]      addr_ext;
  logic             addr_ok;
  logic             store_we;
  logic             wrap_d;

  // Addresses past the store are only reachable when PROG_LEN is not a power of two.
  assign addr_ext = 32'(i_prog_addr);
  assign addr_ok  = (addr_ext < PROG_LEN);
  assign store_we = i_prog_we && addr_ok && (state_q == ST_IDLE);
  assign wr_err_d = i_prog_we && !store_we;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bit_count_d = bit_count_q;
    wrap_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !start_q) begin
          state_d     = ST_RUN;
          pc_d        = '0;
          bit_count_d = '0;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_d     = ST_IDLE;
          pc_d        = '0;
          bit_count_d = '0;
        end else if (i_pcincr) begin
          if (pc_q == LAST_PC) begin
`ifdef SERIAL_SEQ_LOOP_EN
            pc_d        = '0;
            bit_count_d = '0;
            wrap_d      = 1'b1;
`else
            state_d     = ST_DONE;
`endif
          end else begin
            pc_d        = pc_q + PC_W'(1);
            bit_count_d = '0;
          end
        end else begin
          bit_count_d = bit_count_q + BIT_W'(1);
        end
      end
      ST_DONE: begin
        if (i_abort || !i_start) begin
          state_d     = ST_IDLE;
          pc_d        = '0;
          bit_count_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pc_d        = '0;
        bit_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      bit_count_q <= '0;
      start_q     <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      bit_count_q <= bit_count_d;
      start_q     <= i_start;
      wr_err_q    <= wr_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(PROG_LEN); i++) begin
        store_q[i] <= 3'b000;
      end
    end else if (store_we) begin
      store_q[i_prog_addr] <= i_prog_data;
    end
  end

`ifdef SERIAL_SEQ_LOOP_EN
  logic wrap_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign o_wrap = wrap_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_d;
  assign o_wrap      = 1'b0;
`endif

  // Outside RUN the decoder sees the stall opcode.
  assign o_instr     = (state_q == ST_RUN) ? store_q[pc_q] : 3'b001;
  assign o_bit_count = bit_count_q;
  assign o_pc        = pc_q;
  assign o_busy      = (state_q == ST_RUN);
  assign o_done      = (state_q == ST_DONE);
  assign o_wr_err    = wr_err_q;

endmodule
